// File: rtl/branch_unit_if.sv
// Bundle between the core pipeline and the branch unit: fetch-side prediction,
// resolve-side compare flags, and the outcome/statistics returned to the core.
interface branch_unit_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
);
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_taken;
    logic             branch;
    logic [2:0]       funct3;
    logic             ZF;
    logic             SF;
    logic             OF;
    logic             CF;
    logic [PC_W-1:0]  res_pc;
    logic             res_pred;
    logic             PCSrc;
    logic             mispredict;
    logic             illegal_br;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    modport master (
        output fetch_pc, branch, funct3, ZF, SF, OF, CF, res_pc, res_pred,
        input  pred_taken, PCSrc, mispredict, illegal_br, br_count, mp_count
    );

    modport slave (
        input  fetch_pc, branch, funct3, ZF, SF, OF, CF, res_pc, res_pred,
        output pred_taken, PCSrc, mispredict, illegal_br, br_count, mp_count
    );
endinterface

// File: rtl/branch_unit.sv
// RV32I conditional-branch resolver with a bimodal 2-bit-counter predictor and
// saturating counters for resolved branches and mispredictions.
module branch_unit #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned CNT_W      = 16,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input logic          clk,
    input logic          rst_n,
    branch_unit_if.slave bus
);
    localparam int unsigned Depth = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       tbl_q [Depth];
    logic [1:0]       tbl_d [Depth];
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    logic             taken;
    logic             legal;
    logic             upd;
    logic             mp;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       entry_cur;
    logic [1:0]       entry_nxt;
    logic             unused_pc;

    // Word-aligned PCs: drop bits [1:0], alias everything above the index.
    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign res_idx   = bus.res_pc[IDX_W+1:2];
    assign unused_pc = ^{bus.fetch_pc[1:0], bus.fetch_pc[PC_W-1:IDX_W+2],
                         bus.res_pc[1:0], bus.res_pc[PC_W-1:IDX_W+2]};

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (bus.funct3)
            3'b000:  taken = bus.ZF;
            3'b001:  taken = ~bus.ZF;
            3'b100:  taken = bus.SF ^ bus.OF;
            3'b101:  taken = ~(bus.SF ^ bus.OF);
            3'b110:  taken = bus.CF;
            3'b111:  taken = ~bus.CF;
            default: legal = 1'b0;
        endcase
    end

    assign upd = bus.branch & legal;
    assign mp  = upd & (taken != bus.res_pred);

    assign bus.PCSrc      = bus.branch & taken;
    assign bus.illegal_br = bus.branch & ~legal;
    assign bus.mispredict = mp;
    // Read is from the registered table, so a same-cycle update is not bypassed.
    assign bus.pred_taken = tbl_q[fetch_idx][1];
    assign bus.br_count   = br_cnt_q;
    assign bus.mp_count   = mp_cnt_q;

    always_comb begin
        entry_cur = tbl_q[res_idx];
        entry_nxt = entry_cur;
        if (taken) begin
            if (entry_cur != 2'b11) entry_nxt = entry_cur + 2'b01;
        end else begin
            if (entry_cur != 2'b00) entry_nxt = entry_cur - 2'b01;
        end
        tbl_d = tbl_q;
        if (upd) tbl_d[res_idx] = entry_nxt;
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (upd && br_cnt_q != CntMax) br_cnt_d = br_cnt_q + CntOne;
        if (mp && mp_cnt_q != CntMax)  mp_cnt_d = mp_cnt_q + CntOne;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) tbl_q[i] <= INIT_STATE;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            tbl_q    <= tbl_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end
endmodule
